adc_scan_sequencer: RTL and testbench

Channel-scan controller that sits directly upstream and downstream of the LTC2308 single-conversion controller. It issues one-cycle start pulses with a channel number, waits for the conversion-done flag, and averages 2^AVG_LOG2 samples per channel. It stores each channel's averaged 12-bit result in an 8-entry bank readable by the bus side. It provides single-shot and continuous scanning over a channel mask, with a per-conversion timeout.

---
 rtl/adc_scan_pkg.sv | 8 +
 rtl/adc_next_ch.sv | 22 ++
 rtl/adc_scan_sequencer.sv | 148 ++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared states and sizes for the ADC scan sequencer
package adc_scan_pkg;
    localparam int CH_NUM = 8;
    localparam int CH_BITS = $clog2(CH_NUM);
    localparam int DATA_BITS = 12;
    localparam int GUARD_CYCLES = 2;
    typedef enum logic [2:0] {IDLE, START, GUARD, WAIT, ACCUM, NEXT} state_t;
endpackage

// File: rtl/adc_next_ch.sv
// adc_next_ch: priority finder for the next set mask bit above cur_ch, wrapping to the lowest
module adc_next_ch
    import adc_scan_pkg::*;
(
    input  logic [CH_NUM-1:0]  mask,
    input  logic [CH_BITS-1:0] cur_ch,
    output logic [CH_BITS-1:0] next_ch,
    output logic               wrap
);
    // Descending scans so the lowest qualifying bit is the one that sticks
    always_comb begin
        next_ch = '0;
        wrap = 1'b1;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (mask[i]) next_ch = CH_BITS'(i);
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (mask[i] && CH_BITS'(i) > cur_ch) begin
                next_ch = CH_BITS'(i);
                wrap = 1'b0;
            end
    end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: channel-scan controller averaging LTC2308 conversions into a result bank
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_trigger,
    input  logic                 continuous,
    input  logic [CH_NUM-1:0]    ch_mask,
    input  logic                 err_clear,
    output logic                 measure_start,
    output logic [CH_BITS-1:0]   measure_ch,
    input  logic                 measure_done,
    input  logic [DATA_BITS-1:0] measured_data,
    input  logic [CH_BITS-1:0]   rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 sample_valid,
    output logic [CH_BITS-1:0]   sample_ch,
    output logic [DATA_BITS-1:0] sample_value,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int ACC_BITS = DATA_BITS + AVG_LOG2;
    localparam int N_BITS = AVG_LOG2 + 1;
    localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);

    state_t state;
    logic [CH_NUM-1:0] scan_mask;
    logic [CH_BITS-1:0] cur_ch, next_ch, first_ch;
    logic next_wrap, first_wrap, start_ok;
    logic [ACC_BITS-1:0] acc, acc_sum;
    logic [N_BITS-1:0] n, n_inc;
    logic [DATA_BITS-1:0] data_q, avg;
    logic [TMR_BITS-1:0] tmr;
    logic [1:0] gcnt;
    logic [DATA_BITS-1:0] bank [CH_NUM];

    adc_next_ch u_next (.mask(scan_mask), .cur_ch(cur_ch), .next_ch(next_ch), .wrap(next_wrap));
    adc_next_ch u_first (.mask(ch_mask), .cur_ch(CH_BITS'(CH_NUM - 1)), .next_ch(first_ch), .wrap(first_wrap));

    assign start_ok = first_wrap && (ch_mask != '0);
    assign acc_sum = acc + ACC_BITS'(data_q);
    assign n_inc = n + 1'b1;
    assign avg = DATA_BITS'(acc_sum >> AVG_LOG2);
    assign busy = (state != IDLE);

    // Scan FSM: start/guard/wait handshake, averaging, timeout and bank writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            scan_mask <= '0;
            cur_ch <= '0;
            acc <= '0;
            n <= '0;
            data_q <= '0;
            tmr <= '0;
            gcnt <= '0;
            measure_start <= 1'b0;
            measure_ch <= '0;
            sample_valid <= 1'b0;
            sample_ch <= '0;
            sample_value <= '0;
            scan_done <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) bank[i] <= '0;
        end else begin
            measure_start <= 1'b0;
            sample_valid <= 1'b0;
            scan_done <= 1'b0;
            if (err_clear) timeout_err <= 1'b0;
            case (state)
                IDLE: if ((scan_trigger || continuous) && start_ok) begin
                    scan_mask <= ch_mask;
                    cur_ch <= first_ch;
                    measure_ch <= first_ch;
                    measure_start <= 1'b1;
                    acc <= '0;
                    n <= '0;
                    state <= START;
                end
                START: begin
                    gcnt <= '0;
                    state <= GUARD;
                end
                GUARD: if (gcnt == 2'(GUARD_CYCLES - 1)) begin
                    tmr <= '0;
                    state <= WAIT;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                WAIT: if (measure_done) begin
                    data_q <= measured_data;
                    state <= ACCUM;
                end else if (tmr == TMR_BITS'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err <= 1'b1;
                    state <= NEXT;
                end else begin
                    tmr <= tmr + 1'b1;
                end
                ACCUM: if (n_inc == N_BITS'(2 ** AVG_LOG2)) begin
                    bank[cur_ch] <= avg;
                    sample_valid <= 1'b1;
                    sample_ch <= cur_ch;
                    sample_value <= avg;
                    state <= NEXT;
                end else begin
                    acc <= acc_sum;
                    n <= n_inc;
                    measure_ch <= cur_ch;
                    measure_start <= 1'b1;
                    state <= START;
                end
                NEXT: begin
                    acc <= '0;
                    n <= '0;
                    if (!next_wrap) begin
                        cur_ch <= next_ch;
                        measure_ch <= next_ch;
                        measure_start <= 1'b1;
                        state <= START;
                    end else begin
                        scan_done <= 1'b1;
                        if (continuous && start_ok) begin
                            scan_mask <= ch_mask;
                            cur_ch <= first_ch;
                            measure_ch <= first_ch;
                            measure_start <= 1'b1;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered bank read; a same-cycle write is seen only on the next read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else rd_data <= bank[rd_addr];
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: scoreboard bench with a behavioural ADC conversion controller model
module tb_adc_scan_sequencer;
    localparam int CONV = 20;

    logic clk = 1'b0, reset = 1'b1, scan_trigger = 1'b0, continuous = 1'b0, err_clear = 1'b0;
    logic measure_done = 1'b0;
    logic [7:0] ch_mask = '0;
    logic [11:0] measured_data = '0;
    logic [2:0] rd_addr = '0;
    logic measure_start, sample_valid, scan_done, busy, timeout_err;
    logic [2:0] measure_ch, sample_ch;
    logic [11:0] rd_data, sample_value;

    int checks = 0, failures = 0;
    int val [8][4];
    int kcnt [8];
    int starts = 0, scans = 0, stale_hold = 0, hang_ch = -1;
    int left = 0, hold = 0, cur = 0, cyc = 0, last_start = -100, s0 = 0;
    logic [14:0] exp_q [$];
    logic [14:0] exp_e;

    adc_scan_sequencer dut (
        .clk(clk), .reset(reset), .scan_trigger(scan_trigger), .continuous(continuous),
        .ch_mask(ch_mask), .err_clear(err_clear), .measure_start(measure_start),
        .measure_ch(measure_ch), .measure_done(measure_done), .measured_data(measured_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_value(sample_value), .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push(input int ch, input int v);
        exp_q.push_back({3'(ch), 12'(v)});
    endtask

    task automatic trigger();
        scan_trigger = 1'b1;
        tick(1);
        scan_trigger = 1'b0;
    endtask

    task automatic rd(input int a, input int exp, input string name);
        rd_addr = 3'(a);
        tick(1);
        check(name, int'(rd_data), exp);
    endtask

    task automatic wait_scans(input int target, input string name);
        int t = 0;
        while (scans < target && t < 6000) begin
            tick(1);
            t++;
        end
        check(name, int'(scans >= target), 1);
    endtask

    task automatic wait_start(input string name);
        int t = 0;
        while (!measure_start && t < 200) begin
            tick(1);
            t++;
        end
        check(name, int'(measure_start), 1);
    endtask

    // ADC model: done drops on start (or stale_hold cycles later), rises CONV cycles after start
    always @(negedge clk) begin
        cyc++;
        if (measure_start) begin
            check("start_gap", int'(cyc - last_start >= 4), 1);
            last_start = cyc;
            starts++;
            cur = int'(measure_ch);
            left = CONV;
            hold = stale_hold;
            if (hold == 0) measure_done = 1'b0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) measure_done = 1'b0;
            end
            if (left > 0) begin
                left--;
                if (left == 0 && cur != hang_ch) begin
                    measured_data = 12'(val[cur][kcnt[cur]]);
                    measure_done = 1'b1;
                    kcnt[cur] = (kcnt[cur] + 1) % 4;
                end
            end
        end
    end

    // Monitor: pop the scoreboard on every sample_valid and count scan_done pulses
    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample: got ch%0d value %0d expected none", sample_ch, sample_value);
            end else begin
                exp_e = exp_q.pop_front();
                check("sample_ch", int'(sample_ch), int'(exp_e[14:12]));
                check("sample_value", int'(sample_value), int'(exp_e[11:0]));
            end
        end
        if (scan_done) scans++;
    end

    initial begin
        foreach (val[i, j]) val[i][j] = 0;
        foreach (kcnt[i]) kcnt[i] = 0;
        val[0] = '{100, 101, 102, 103};
        val[1] = '{10, 20, 30, 41};
        val[2] = '{4000, 4000, 4000, 4000};
        val[4] = '{4095, 4095, 4095, 4095};
        val[7] = '{7, 8, 9, 10};
        tick(3);
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(measure_start), 0);
        check("rst_err", int'(timeout_err), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_rd", int'(rd_data), 0);
        reset = 1'b0;
        tick(2);

        ch_mask = 8'h05;
        push(0, 101);
        push(2, 4000);
        starts = 0;
        trigger();
        wait_scans(1, "single_scan_done");
        check("single_starts", starts, 8);
        rd(2, 4000, "single_rd_ch2");
        rd(0, 101, "single_rd_ch0");

        stale_hold = 1;
        ch_mask = 8'h12;
        push(1, 25);
        push(4, 4095);
        starts = 0;
        trigger();
        wait_scans(2, "stale_scan_done");
        check("stale_starts", starts, 8);
        stale_hold = 0;

        hang_ch = 1;
        ch_mask = 8'h03;
        push(0, 101);
        trigger();
        wait_scans(3, "timeout_scan_done");
        check("timeout_err_set", int'(timeout_err), 1);
        rd(1, 25, "timeout_ch1_kept");
        rd(0, 101, "timeout_ch0_ok");
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("err_cleared", int'(timeout_err), 0);
        hang_ch = -1;

        ch_mask = 8'h80;
        push(7, 8);
        push(0, 101);
        continuous = 1'b1;
        wait_start("cont_first_start");
        check("cont_first_ch", int'(measure_ch), 7);
        ch_mask = 8'h01;
        wait_scans(4, "cont_scan1_done");
        continuous = 1'b0;
        wait_scans(5, "cont_scan2_done");
        tick(3);
        check("cont_idle", int'(busy), 0);
        check("cont_scan_count", scans, 5);
        rd(7, 8, "cont_rd_ch7");

        ch_mask = 8'h00;
        s0 = starts;
        trigger();
        tick(3);
        check("zero_busy", int'(busy), 0);
        check("zero_no_start", starts, s0);
        ch_mask = 8'h04;
        push(2, 4000);
        trigger();
        tick(10);
        trigger();
        wait_scans(6, "busy_trig_done");
        tick(200);
        check("busy_trig_one_scan", scans, 6);
        check("busy_trig_idle", int'(busy), 0);

        trigger();
        wait_start("rst_mid_start");
        tick(6);
        #2 reset = 1'b1;
        tick(1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_start_low", int'(measure_start), 0);
        check("rst_mid_valid", int'(sample_valid), 0);
        tick(40);
        foreach (kcnt[i]) kcnt[i] = 0;
        reset = 1'b0;
        rd(2, 0, "rst_bank2_cleared");
        rd(0, 0, "rst_bank0_cleared");
        push(2, 4000);
        trigger();
        wait_scans(7, "rescan_done");
        rd(2, 4000, "rescan_rd_ch2");

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
